// File: rtl/myo_spi_slave_frame.sv
// rtl/myo_spi_slave_frame.sv - SPI mode-0 slave with framed word RX/TX and per-frame status
// Optional feature macro: SPI_FRAME_CHECKSUM_EN (last word of a frame is a modulo-sum checksum)
module myo_spi_slave_frame #(
   parameter int WORD_BITS = 16,
   parameter int MAX_WORDS = 12,
   parameter int IDXW      = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 sclk,
   input  logic                 ss_n,
   input  logic                 mosi,
   output logic                 miso,
   output logic                 miso_oe,
   input  logic [WORD_BITS-1:0] tx_data,
   output logic [IDXW-1:0]      tx_index,
   output logic [WORD_BITS-1:0] rx_data,
   output logic [IDXW-1:0]      rx_index,
   output logic                 rx_valid,
   output logic                 frame_done,
   output logic [IDXW-1:0]      frame_words,
   output logic                 frame_ok
);
   localparam int              BCW      = $clog2(WORD_BITS + 1);
   localparam logic [IDXW-1:0] MAX_IDX  = IDXW'(MAX_WORDS);
   localparam logic [BCW-1:0]  LAST_BIT = BCW'(WORD_BITS);

   typedef enum logic [1:0] {RESYNC, IDLE, ACTIVE, DONE} state_t;
   state_t state_q, state_d;

   // synchroniser stages reset to 0 so a low ss_n after reset is never mistaken for idle
   logic sclk_m_q, sclk_s_q, sclk_p_q;
   logic ss_m_q, ss_s_q, ss_p_q;
   logic mosi_m_q, mosi_s_q;

   logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [IDXW-1:0]      word_cnt_q, word_cnt_d;
   logic [IDXW-1:0]      tx_index_q, tx_index_d;
   logic [WORD_BITS-1:0] sh_rx_q, sh_rx_d;
   logic [WORD_BITS-1:0] sh_tx_q, sh_tx_d;
   logic                 ovf_q, ovf_d;
   logic                 miso_q, miso_d;
   logic                 miso_oe_q, miso_oe_d;
   logic [WORD_BITS-1:0] rx_data_q, rx_data_d;
   logic [IDXW-1:0]      rx_index_q, rx_index_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 frame_done_q, frame_done_d;
   logic [IDXW-1:0]      frame_words_q, frame_words_d;
   logic                 frame_ok_q, frame_ok_d;
`ifdef SPI_FRAME_CHECKSUM_EN
   logic [WORD_BITS-1:0] rx_sum_q, rx_sum_d;
   logic [WORD_BITS-1:0] rx_last_q, rx_last_d;
   logic [WORD_BITS-1:0] tx_cur_q, tx_cur_d;
   logic [WORD_BITS-1:0] tx_sum_q, tx_sum_d;
`endif

   logic sclk_rise, sclk_fall, ss_rise, ss_fall;
   logic [WORD_BITS-1:0] tx_word;
   logic frame_ok_calc;

   assign sclk_rise = sclk_s_q & ~sclk_p_q;
   assign sclk_fall = ~sclk_s_q & sclk_p_q;
   assign ss_rise   = ss_s_q & ~ss_p_q;
   assign ss_fall   = ~ss_s_q & ss_p_q;

   // words past MAX_WORDS are sent as zero
   assign tx_word = (tx_index_q == MAX_IDX) ? '0 : tx_data;

   // rx_sum excludes the most recent word, so a match means last word == sum of the ones before it
`ifdef SPI_FRAME_CHECKSUM_EN
   assign frame_ok_calc = (bit_cnt_q == '0) && !ovf_q && (word_cnt_q >= IDXW'(2)) &&
                          (rx_sum_q == rx_last_q);
`else
   assign frame_ok_calc = (bit_cnt_q == '0) && !ovf_q && (word_cnt_q != '0);
`endif

   // frame FSM and datapath next state; ss_n events win over sclk edges in the same cycle
   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      word_cnt_d    = word_cnt_q;
      tx_index_d    = tx_index_q;
      sh_rx_d       = sh_rx_q;
      sh_tx_d       = sh_tx_q;
      ovf_d         = ovf_q;
      miso_d        = miso_q;
      miso_oe_d     = miso_oe_q;
      rx_data_d     = rx_data_q;
      rx_index_d    = rx_index_q;
      rx_valid_d    = 1'b0;
      frame_done_d  = 1'b0;
      frame_words_d = frame_words_q;
      frame_ok_d    = frame_ok_q;
`ifdef SPI_FRAME_CHECKSUM_EN
      rx_sum_d      = rx_sum_q;
      rx_last_d     = rx_last_q;
      tx_cur_d      = tx_cur_q;
      tx_sum_d      = tx_sum_q;
`endif
      unique case (state_q)
         RESYNC: begin
            if (ss_s_q) state_d = IDLE;
         end
         IDLE: begin
            if (ss_fall) begin
               state_d    = ACTIVE;
               bit_cnt_d  = '0;
               word_cnt_d = '0;
               tx_index_d = '0;
               ovf_d      = 1'b0;
               sh_tx_d    = tx_data;
               miso_d     = tx_data[WORD_BITS-1];
               miso_oe_d  = 1'b1;
`ifdef SPI_FRAME_CHECKSUM_EN
               rx_sum_d   = '0;
               rx_last_d  = '0;
               tx_cur_d   = tx_data;
               tx_sum_d   = '0;
`endif
            end
         end
         ACTIVE: begin
            if (ss_rise) begin
               state_d       = DONE;
               frame_done_d  = 1'b1;
               frame_words_d = word_cnt_q;
               frame_ok_d    = frame_ok_calc;
               miso_oe_d     = 1'b0;
               miso_d        = 1'b0;
               tx_index_d    = '0;
            end else if (bit_cnt_q == LAST_BIT) begin
               bit_cnt_d = '0;
               if (word_cnt_q == MAX_IDX) begin
                  ovf_d = 1'b1;
               end else begin
                  rx_valid_d = 1'b1;
                  rx_data_d  = sh_rx_q;
                  rx_index_d = word_cnt_q;
                  word_cnt_d = word_cnt_q + 1'b1;
`ifdef SPI_FRAME_CHECKSUM_EN
                  rx_sum_d   = rx_sum_q + rx_last_q;
                  rx_last_d  = sh_rx_q;
                  tx_sum_d   = tx_sum_q + tx_cur_q;
`endif
               end
               if (tx_index_q != MAX_IDX) tx_index_d = tx_index_q + 1'b1;
            end else if (sclk_rise) begin
               sh_rx_d   = {sh_rx_q[WORD_BITS-2:0], mosi_s_q};
               bit_cnt_d = bit_cnt_q + 1'b1;
            end else if (sclk_fall) begin
               if (bit_cnt_q == '0) begin
                  sh_tx_d  = tx_word;
                  miso_d   = tx_word[WORD_BITS-1];
`ifdef SPI_FRAME_CHECKSUM_EN
                  tx_cur_d = tx_word;
`endif
               end else begin
                  sh_tx_d = sh_tx_q << 1;
                  miso_d  = sh_tx_q[WORD_BITS-2];
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = RESYNC;
      endcase
   end

   // state, synchroniser and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= RESYNC;
         sclk_m_q      <= 1'b0;
         sclk_s_q      <= 1'b0;
         sclk_p_q      <= 1'b0;
         ss_m_q        <= 1'b0;
         ss_s_q        <= 1'b0;
         ss_p_q        <= 1'b0;
         mosi_m_q      <= 1'b0;
         mosi_s_q      <= 1'b0;
         bit_cnt_q     <= '0;
         word_cnt_q    <= '0;
         tx_index_q    <= '0;
         sh_rx_q       <= '0;
         sh_tx_q       <= '0;
         ovf_q         <= 1'b0;
         miso_q        <= 1'b0;
         miso_oe_q     <= 1'b0;
         rx_data_q     <= '0;
         rx_index_q    <= '0;
         rx_valid_q    <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_words_q <= '0;
         frame_ok_q    <= 1'b0;
`ifdef SPI_FRAME_CHECKSUM_EN
         rx_sum_q      <= '0;
         rx_last_q     <= '0;
         tx_cur_q      <= '0;
         tx_sum_q      <= '0;
`endif
      end else begin
         state_q       <= state_d;
         sclk_m_q      <= sclk;
         sclk_s_q      <= sclk_m_q;
         sclk_p_q      <= sclk_s_q;
         ss_m_q        <= ss_n;
         ss_s_q        <= ss_m_q;
         ss_p_q        <= ss_s_q;
         mosi_m_q      <= mosi;
         mosi_s_q      <= mosi_m_q;
         bit_cnt_q     <= bit_cnt_d;
         word_cnt_q    <= word_cnt_d;
         tx_index_q    <= tx_index_d;
         sh_rx_q       <= sh_rx_d;
         sh_tx_q       <= sh_tx_d;
         ovf_q         <= ovf_d;
         miso_q        <= miso_d;
         miso_oe_q     <= miso_oe_d;
         rx_data_q     <= rx_data_d;
         rx_index_q    <= rx_index_d;
         rx_valid_q    <= rx_valid_d;
         frame_done_q  <= frame_done_d;
         frame_words_q <= frame_words_d;
         frame_ok_q    <= frame_ok_d;
`ifdef SPI_FRAME_CHECKSUM_EN
         rx_sum_q      <= rx_sum_d;
         rx_last_q     <= rx_last_d;
         tx_cur_q      <= tx_cur_d;
         tx_sum_q      <= tx_sum_d;
`endif
      end
   end

   assign miso        = miso_q;
   assign miso_oe     = miso_oe_q;
   assign tx_index    = tx_index_q;
   assign rx_data     = rx_data_q;
   assign rx_index    = rx_index_q;
   assign rx_valid    = rx_valid_q;
   assign frame_done  = frame_done_q;
   assign frame_words = frame_words_q;
   assign frame_ok    = frame_ok_q;

endmodule
